// File: rtl/rosc_stress_sequencer.sv
// rosc_stress_sequencer: timed AC/DC stress of N_CH ring oscillators followed by per-channel edge-count measurement.
// Define ROSC_SAT_CNT_EN for a saturating edge counter with sticky OVF; otherwise the counter wraps and OVF is 0.
module rosc_stress_sequencer #(
    parameter int N_CH   = 3,
    parameter int CNT_W  = 16,
    parameter int TMR_W  = 24,
    parameter int SETTLE = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             AC_DC,
    input  logic [N_CH-1:0]  CH_MASK,
    input  logic [TMR_W-1:0] STRESS_CYCLES,
    input  logic [TMR_W-1:0] GATE_CYCLES,
    input  logic [N_CH-1:0]  RO_OUT,
    output logic             MEAS_STRESS,
    output logic [N_CH-1:0]  EN_ROSC,
    output logic [N_CH-1:0]  SEL,
    output logic [CNT_W-1:0] COUNT,
    output logic [3:0]       COUNT_CH,
    output logic             COUNT_VALID,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);
    typedef enum logic [2:0] {S_IDLE, S_STRESS, S_SETTLE, S_GATE, S_STORE, S_FINISH} state_t;

    state_t            state_q, state_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [TMR_W-1:0]  gate_q;
    logic [N_CH-1:0]   mask_q;
    logic              ac_q;
    logic              armed_q;
    logic [2:0]        sync_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  count_q;
    logic [3:0]        count_ch_q;
    logic              cv_q;
    logic              done_q;
    logic              accept;
    logic              rise;
    logic              meas;
    logic [N_CH-1:0]   onehot;
    logic [4:0]        low_start, low_mask, nxt;

    // Returns {found, index} of the lowest set bit of m at or above lo.
    function automatic logic [4:0] first_set(input logic [N_CH-1:0] m, input int lo);
        first_set = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (m[i] && i >= lo) first_set = {1'b1, 4'(i)};
    endfunction

    // armed_q blocks a START that coincides with reset release.
    assign accept    = (state_q == S_IDLE) && START && armed_q;
    assign low_start = first_set(CH_MASK, 0);
    assign low_mask  = first_set(mask_q, 0);
    assign nxt       = first_set(mask_q, int'(ptr_q) + 1);
    assign onehot    = N_CH'(1) << ptr_q;
    assign meas      = (state_q == S_SETTLE) || (state_q == S_GATE);
    assign rise      = sync_q[1] & ~sync_q[2];

    assign MEAS_STRESS = (state_q == S_STRESS);
    assign EN_ROSC     = (state_q == S_STRESS) ? (ac_q ? mask_q : '0) : (meas ? onehot : '0);
    assign SEL         = meas ? onehot : '0;
    assign BUSY        = (state_q != S_IDLE);
    assign COUNT       = count_q;
    assign COUNT_CH    = count_ch_q;
    assign COUNT_VALID = cv_q;
    assign DONE        = done_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (CH_MASK == '0) state_d = S_FINISH;
                else if (STRESS_CYCLES == '0) begin
                    state_d = S_SETTLE;
                    ptr_d   = low_start[3:0];
                    tmr_d   = TMR_W'(SETTLE);
                end else begin
                    state_d = S_STRESS;
                    tmr_d   = STRESS_CYCLES;
                end
            end
            S_STRESS: if (tmr_q <= TMR_W'(1)) begin
                state_d = S_SETTLE;
                ptr_d   = low_mask[3:0];
                tmr_d   = TMR_W'(SETTLE);
            end else tmr_d = tmr_q - 1'b1;
            S_SETTLE: if (tmr_q <= TMR_W'(1)) begin
                state_d = S_GATE;
                tmr_d   = gate_q;
            end else tmr_d = tmr_q - 1'b1;
            S_GATE: if (tmr_q <= TMR_W'(1)) state_d = S_STORE;
                    else tmr_d = tmr_q - 1'b1;
            S_STORE: if (nxt[4]) begin
                state_d = S_SETTLE;
                ptr_d   = nxt[3:0];
                tmr_d   = TMR_W'(SETTLE);
            end else state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            tmr_q      <= '0;
            gate_q     <= '0;
            mask_q     <= '0;
            ac_q       <= 1'b0;
            armed_q    <= 1'b0;
            sync_q     <= '0;
            count_q    <= '0;
            count_ch_q <= '0;
            cv_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            armed_q <= 1'b1;
            sync_q  <= {sync_q[1:0], |(RO_OUT & onehot)};
            cv_q    <= (state_q == S_STORE);
            done_q  <= (state_q == S_FINISH);
            if (accept) begin
                gate_q <= GATE_CYCLES;
                mask_q <= CH_MASK;
                ac_q   <= AC_DC;
            end
            if (state_q == S_STORE) begin
                count_q    <= cnt_q;
                count_ch_q <= ptr_q;
            end
        end
    end

`ifdef ROSC_SAT_CNT_EN
    logic ovf_q;
    assign OVF = ovf_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (state_q == S_SETTLE) cnt_q <= '0;
            else if (state_q == S_GATE && rise) begin
                if (&cnt_q) ovf_q <= 1'b1;
                else cnt_q <= cnt_q + 1'b1;
            end
            if (accept) ovf_q <= 1'b0;
        end
    end
`else
    assign OVF = 1'b0;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else if (state_q == S_SETTLE) cnt_q <= '0;
        else if (state_q == S_GATE && rise) cnt_q <= cnt_q + 1'b1;
    end
`endif
endmodule
